mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Parametrised MEM pipeline stage with a load/store unit. Registers the EX->MEM bundle and aligns
//  sub-word loads (LB/LBU/LH/LHU/LW). Waits on a variable-latency data SRAM via a valid handshake.
//  Sits between EX and WB. Drives the WB bundle, the RF forwarding bundle and a stall request to the
//  pipeline controller.
// PARAMETERS
//  DATA_W     32  data/result width (32 or 64); byte lanes = DATA_W/8
//  RF_AW       5  register-file address width
//  PC_W       32  pc width
//  TIMEOUT   255  max cycles to wait for dmem_rvalid before declaring bus error (>=1)
// PORTS
//  clk          in   1             clock
//  rst          in   1             synchronous, active-high reset
//  stall_mem    in   1             hold MEM input register
//  stall_wb     in   1             hold WB (downstream)
//  ex_valid     in   1             EX bundle valid
//  ex_pc        in   PC_W          instruction pc
//  ex_ld        in   1             instruction is a load
//  ex_ls_op     in   3             0 LB,1 LBU,2 LH,3 LHU,4 LW (5..7 reserved = LW)
//  ex_rf_we     in   1             writes register file
//  ex_rf_waddr  in   RF_AW         destination register
//  ex_result    in   DATA_W        ALU result / effective address
//  dmem_rvalid  in   1             read data valid (1-cycle pulse)
//  dmem_rdata   in   DATA_W        read data, word-aligned
//  stall_req    out  1             MEM requests pipeline freeze
//  bus_err      out  1             1-cycle pulse on load timeout
//  wb_valid     out  1             WB bundle valid
//  wb_pc        out  PC_W          pc to WB
//  wb_rf_we     out  1             RF write enable to WB
//  wb_rf_waddr  out  RF_AW         RF address to WB
//  wb_rf_wdata  out  DATA_W        RF data to WB
//  fwd_we       out  1             forwarding write enable (0 while load pending)
//  fwd_waddr    out  RF_AW         forwarding address
//  fwd_wdata    out  DATA_W        forwarding data
// BEHAVIOUR
//  - Input reg: rst -> all 0. stall_mem&!stall_wb -> load bubble (all 0). !stall_mem -> capture EX.
//    stall_mem&stall_wb -> hold.
//  - FSM IDLE/WAIT/DONE, reset IDLE. IDLE: registered valid load -> WAIT, unless dmem_rvalid is
//    already high that cycle -> DONE path directly (0-wait).
//  - WAIT: dmem_rvalid -> latch aligned data, DONE. Counter reaches TIMEOUT -> bus_err pulse,
//    rf_we forced 0, then DONE.
//  - DONE: stays until the input reg advances (!stall_mem), then IDLE.
//  - stall_req = (state==WAIT) | (IDLE & valid load & !dmem_rvalid); combinational.
//  - Counter clears on entry to WAIT and saturates at TIMEOUT.
//  - Alignment uses ex_result[log2(DATA_W/8)-1:0] as the byte offset.
//    LB/LBU pick the byte at that offset; LH/LHU pick the halfword at offset&~1.
//    LW: for DATA_W=32 the full word; for DATA_W=64 the 32-bit word at offset[2], sign-extended.
//    LB/LH sign-extend to DATA_W; LBU/LHU zero-extend.
//  - Load captured data is held in a DATA_W reg; it is not re-sampled while DONE.
//  - wb_rf_wdata = load ? aligned data : ex_result. wb_valid = reg valid & !stall_req.
//    When !wb_valid, wb_rf_we=0.
//  - fwd_*: same values as wb_*, but fwd_we=0 while stall_req (consumer must stall, not forward).
//  - dmem_rvalid when no load pending: ignored.
//  - rst mid-WAIT: FSM IDLE, counter 0, all outputs 0 next cycle. A late rvalid is ignored.
//  - All outputs are 0 in the cycle after rst.
// CONFIGURATION
//  MEM_MISALIGN_EXC_EN defined: LH/LHU with offset[0]=1, or LW with offset[1:0]!=0, is misaligned.
//    No wait is entered: stall_req stays 0, bus_err pulses 1 cycle, wb_rf_we=0, wb_valid=1.
//  Undefined: the offset low bits are silently masked (offset&~1 for halfwords, word-aligned for LW);
//    no error is reported.
// TESTING
//  - ALU op ex_result=0x1234_5678, rf_we=1, waddr=5, no stall -> next cycle wb_rf_wdata=0x12345678,
//    fwd_we=1, stall_req=0.
//  - LB, addr offset 3, rdata=0x80FF_0000 after 2 wait cycles -> stall_req high 2 cycles,
//    then wb_rf_wdata=0xFFFF_FF80.
//    Same with LBU -> 0x0000_0080.
//  - LH, offset 2, rdata=0x7FFF_1234 same cycle -> no stall, wdata=0x0000_7FFF.
//    LHU offset 0 with rdata=0x0000_8001 -> 0x0000_8001.
//  - TIMEOUT=4, LW, no rvalid -> stall_req high 4 cycles, bus_err 1-cycle pulse, wb_rf_we=0,
//    pipeline resumes.
//  - stall_mem=1,stall_wb=0 -> bubble: wb_valid=0, wb_rf_we=0.
//    stall_mem=1,stall_wb=1 -> outputs unchanged.
//  - rst asserted during WAIT, then rvalid pulse -> no write, state IDLE, outputs 0.
//    Misaligned LW at offset 1 -> bus_err with MEM_MISALIGN_EXC_EN; masked word load without it.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// MEM-stage port bundle: EX inputs, data-SRAM response, WB/forwarding outputs, stall lines.
// Latency: none (wiring only).
// Backpressure: stall_mem/stall_wb in, stall_req out; the slave modport is the MEM stage's view.
interface mem_stage_lsu_if #(
  parameter int DATA_W = 32,
  parameter int RF_AW  = 5,
  parameter int PC_W   = 32
);
  logic              stall_mem;
  logic              stall_wb;
  logic              ex_valid;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_ld;
  logic [2:0]        ex_ls_op;
  logic              ex_rf_we;
  logic [RF_AW-1:0]  ex_rf_waddr;
  logic [DATA_W-1:0] ex_result;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              stall_req;
  logic              bus_err;
  logic              wb_valid;
  logic [PC_W-1:0]   wb_pc;
  logic              wb_rf_we;
  logic [RF_AW-1:0]  wb_rf_waddr;
  logic [DATA_W-1:0] wb_rf_wdata;
  logic              fwd_we;
  logic [RF_AW-1:0]  fwd_waddr;
  logic [DATA_W-1:0] fwd_wdata;

  modport slave (
    input  stall_mem, stall_wb, ex_valid, ex_pc, ex_ld, ex_ls_op, ex_rf_we, ex_rf_waddr,
           ex_result, dmem_rvalid, dmem_rdata,
    output stall_req, bus_err, wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
           fwd_we, fwd_waddr, fwd_wdata
  );

  modport master (
    output stall_mem, stall_wb, ex_valid, ex_pc, ex_ld, ex_ls_op, ex_rf_we, ex_rf_waddr,
           ex_result, dmem_rvalid, dmem_rdata,
    input  stall_req, bus_err, wb_valid, wb_pc, wb_rf_we, wb_rf_waddr, wb_rf_wdata,
           fwd_we, fwd_waddr, fwd_wdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage with load/store unit: registers the EX bundle, aligns sub-word loads.
// Latency: 1 cycle for ALU ops and 0-wait loads; loads add the SRAM wait (bounded by TIMEOUT).
// Backpressure: raises stall_req while a load waits; holds on stall_mem&stall_wb, bubbles on stall_mem only.
// Optional build macro MEM_MISALIGN_EXC_EN: misaligned LH/LHU/LW raise bus_err instead of masking.
module mem_stage_lsu #(
  parameter int DATA_W  = 32,
  parameter int RF_AW   = 5,
  parameter int PC_W    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_stage_lsu_if.slave bus
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The IDLE request cycle is the first stalled cycle, so the WAIT cycle with this
  // count is the TIMEOUT-th stalled cycle.
  localparam int TO_LAST = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic              ld;
    logic [2:0]        ls_op;
    logic              rf_we;
    logic [RF_AW-1:0]  waddr;
    logic [DATA_W-1:0] result;
  } mem_reg_t;

  mem_reg_t          r;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] ld_data_q;
  logic              err_q;

  logic [OFF_W-1:0]  off, off_h, off_w;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  logic [31:0]       ld_w;
  logic [DATA_W-1:0] aligned;
  logic              misalign;
  logic              load_q, hold, timeout_hit, in_done, err_now;

  assign load_q      = r.valid & r.ld;
  assign hold        = bus.stall_mem & bus.stall_wb;
  assign timeout_hit = (cnt >= CNT_W'(TO_LAST));
  assign in_done     = (state == S_DONE);
  assign off         = r.result[OFF_W-1:0];
  assign off_h       = off & ~OFF_W'(1);
  assign off_w       = off & ~OFF_W'(3);

  // Input register: capture EX, insert a bubble when only MEM stalls, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst || (bus.stall_mem && !bus.stall_wb)) begin
      r <= '0;
    end else if (!bus.stall_mem) begin
      r.valid  <= bus.ex_valid;
      r.pc     <= bus.ex_pc;
      r.ld     <= bus.ex_ld;
      r.ls_op  <= bus.ex_ls_op;
      r.rf_we  <= bus.ex_rf_we;
      r.waddr  <= bus.ex_rf_waddr;
      r.result <= bus.ex_result;
    end
  end

  // Sub-word extraction from the word-aligned read data at the registered byte offset.
  always_comb begin
    ld_b = 8'(bus.dmem_rdata >> {off, 3'b000});
    ld_h = 16'(bus.dmem_rdata >> {off_h, 3'b000});
    ld_w = 32'(bus.dmem_rdata >> {off_w, 3'b000});
    case (r.ls_op)
      3'd0:    aligned = DATA_W'($signed(ld_b));
      3'd1:    aligned = DATA_W'(ld_b);
      3'd2:    aligned = DATA_W'($signed(ld_h));
      3'd3:    aligned = DATA_W'(ld_h);
      default: aligned = DATA_W'($signed(ld_w));
    endcase
  end

`ifdef MEM_MISALIGN_EXC_EN
  // Flag halfword loads on odd bytes and word loads off a 4-byte boundary.
  always_comb begin
    misalign = 1'b0;
    if (r.ls_op == 3'd2 || r.ls_op == 3'd3) begin
      misalign = off[0];
    end else if (r.ls_op >= 3'd4) begin
      misalign = (off[1:0] != 2'b00);
    end
  end
`else
  // Low offset bits are masked by the alignment logic; nothing is misaligned.
  assign misalign = 1'b0;
`endif

  // Load FSM: completion goes to DONE only while the register is held, so the next
  // instruction never sees a stale DONE. Timeouts latch zero data and an error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_q) begin
            if (misalign || bus.dmem_rvalid) begin
              ld_data_q <= aligned;
              err_q     <= misalign;
              state     <= hold ? S_DONE : S_IDLE;
            end else begin
              cnt   <= '0;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (bus.dmem_rvalid) begin
            ld_data_q <= aligned;
            err_q     <= 1'b0;
            state     <= hold ? S_DONE : S_IDLE;
          end else if (timeout_hit) begin
            ld_data_q <= '0;
            err_q     <= 1'b1;
            state     <= hold ? S_DONE : S_IDLE;
          end else if (cnt != CNT_W'(TIMEOUT)) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (!hold) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall, error and WB/forwarding outputs; a pending load never forwards.
  always_comb begin
    bus.stall_req = (state == S_WAIT) |
                    ((state == S_IDLE) & load_q & ~bus.dmem_rvalid & ~misalign);
    bus.bus_err   = ((state == S_WAIT) & ~bus.dmem_rvalid & timeout_hit) |
                    ((state == S_IDLE) & load_q & misalign);
    err_now       = ((state == S_IDLE) & load_q & misalign) | (in_done & err_q);
    bus.wb_valid  = r.valid & ~bus.stall_req;
    bus.wb_pc     = r.pc;
    bus.wb_rf_we  = bus.wb_valid & r.rf_we & ~(r.ld & err_now);
    bus.wb_rf_waddr = r.waddr;
    bus.wb_rf_wdata = r.ld ? (in_done ? ld_data_q : aligned) : r.result;
    bus.fwd_we    = bus.wb_rf_we & ~bus.stall_req;
    bus.fwd_waddr = r.waddr;
    bus.fwd_wdata = bus.wb_rf_wdata;
  end
endmodule
